// File: rtl/bloom_pkg.sv
// Shared definitions for the Bloom-filter bit array.
// Holds the default geometry (hash count, hash width, counter width),
// the packed hash vector type and the controller state encoding.
package bloom_pkg;

  localparam int DEF_HASH_CNT   = 10;
  localparam int DEF_HASH_WIDTH = 12;
  localparam int DEF_CNT_WIDTH  = 16;

  // Element [i] addresses bank i; element [0] sits in the low bits.
  typedef logic [DEF_HASH_CNT-1:0][DEF_HASH_WIDTH-1:0] hash_vec_t;

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

endpackage

// File: rtl/bloom_bit_array_bank.sv
// One Bloom bit bank: 2^AW x 1-bit simple dual-port RAM.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address, sampled every cycle
//   rdata_o  registered read data (old contents on a same-address write)
// The array has no reset; contents are defined by the controller's sweep.
module bloom_bank_ram #(
  parameter int AW = 12
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic          wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic          rdata_o
);

  logic mem_q [2**AW];
  logic rdata_q;

  // Both statements use non-blocking assignment, so a read of the address
  // being written in the same cycle returns the previous contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bloom_bit_array.sv
// Bloom-filter bit array: HASH_CNT independent 1-bit banks, one per hash.
// Lookup reports whether every addressed bit is set; program sets them.
// A clear sweep wipes all banks after reset or on clear_i.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   clear_i                 start (or restart) a full wipe
//   prog_hash_i/prog_val_i  program request, accepted with prog_ready_o
//   hash_i/hash_val_i       lookup request, one per cycle, no backpressure
//   match_o/match_val_o     lookup result, two cycles after the request
//   busy_o                  clear sweep in progress
//   prog_cnt_o              saturating count of accepted programs since clear
//
// state    | meaning
// ST_CLEAR | sweeping clr_addr over all banks writing 0; lookups forced miss
// ST_IDLE  | banks valid; programs accepted unless clear_i is asserted
module bloom_bit_array
  import bloom_pkg::*;
#(
  parameter int HASH_CNT   = DEF_HASH_CNT,
  parameter int HASH_WIDTH = DEF_HASH_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           clear_i,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] prog_hash_i,
  input  logic                           prog_val_i,
  output logic                           prog_ready_o,
  input  logic [HASH_CNT*HASH_WIDTH-1:0] hash_i,
  input  logic                           hash_val_i,
  output logic                           match_o,
  output logic                           match_val_o,
  output logic                           busy_o,
  output logic [CNT_WIDTH-1:0]           prog_cnt_o
);

  state_t                state_q, state_d;
  logic [HASH_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic [CNT_WIDTH-1:0]  prog_cnt_q, prog_cnt_d;
  logic                  look_v_q, look_busy_q;
  logic                  match_q, match_val_q;
  logic                  busy, prog_acc;
  logic [HASH_CNT-1:0]   rd_bits;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_CLEAR;
      clr_addr_q  <= '0;
      prog_cnt_q  <= '0;
      look_v_q    <= 1'b0;
      look_busy_q <= 1'b0;
      match_q     <= 1'b0;
      match_val_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      prog_cnt_q  <= prog_cnt_d;
      look_v_q    <= hash_val_i;
      // A lookup issued while clearing, or alongside an accepted clear,
      // carries its own miss flag so it cannot hit on stale bits.
      look_busy_q <= busy | clear_i;
      match_q     <= look_v_q & ~look_busy_q & (&rd_bits);
      match_val_q <= look_v_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_CLEAR: begin
        if (clear_i) begin
          clr_addr_d = '0;
        end else if (clr_addr_q == '1) begin
          state_d    = ST_IDLE;
          clr_addr_d = '0;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (clear_i) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
        end
      end
      default: begin
        state_d    = ST_CLEAR;
        clr_addr_d = '0;
      end
    endcase
  end

  assign busy     = (state_q == ST_CLEAR);
  assign prog_acc = prog_val_i & prog_ready_o;

  always_comb begin
    prog_cnt_d = prog_cnt_q;
    if (clear_i) begin
      prog_cnt_d = '0;
    end else if (prog_acc && (prog_cnt_q != '1)) begin
      prog_cnt_d = prog_cnt_q + 1'b1;
    end
  end

  for (genvar g = 0; g < HASH_CNT; g++) begin : g_bank
    logic [HASH_WIDTH-1:0] waddr;
    assign waddr = busy ? clr_addr_q : prog_hash_i[g*HASH_WIDTH +: HASH_WIDTH];

    bloom_bank_ram #(
      .AW (HASH_WIDTH)
    ) u_bank (
      .clk_i   (clk_i),
      .we_i    (busy | prog_acc),
      .waddr_i (waddr),
      .wdata_i (~busy),
      .raddr_i (hash_i[g*HASH_WIDTH +: HASH_WIDTH]),
      .rdata_o (rd_bits[g])
    );
  end

  assign prog_ready_o = (state_q == ST_IDLE) & ~clear_i;
  assign busy_o       = busy;
  assign match_o      = match_q;
  assign match_val_o  = match_val_q;
  assign prog_cnt_o   = prog_cnt_q;

endmodule

// File: tb/tb_bloom_bit_array.sv
module tb_bloom_bit_array;
  import bloom_pkg::*;

  localparam int NH    = DEF_HASH_CNT;
  localparam int HW    = DEF_HASH_WIDTH;
  localparam int DEPTH = 2**HW;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            clear_i = 1'b0;
  hash_vec_t       prog_hash_i = '0;
  logic            prog_val_i = 1'b0;
  logic            prog_ready_o;
  hash_vec_t       hash_i = '0;
  logic            hash_val_i = 1'b0;
  logic            match_o, match_val_o, busy_o;
  logic [DEF_CNT_WIDTH-1:0] prog_cnt_o;

  always #5 clk = ~clk;

  bloom_bit_array dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .prog_hash_i  (prog_hash_i),
    .prog_val_i   (prog_val_i),
    .prog_ready_o (prog_ready_o),
    .hash_i       (hash_i),
    .hash_val_i   (hash_val_i),
    .match_o      (match_o),
    .match_val_o  (match_val_o),
    .busy_o       (busy_o),
    .prog_cnt_o   (prog_cnt_o)
  );

  // Reference model: a set of programmed bits per bank, a sweep countdown
  // and the result expected two cycles after each request.
  bit [DEPTH-1:0] bank_m [NH];
  bit  m_busy;
  int  m_left;
  int  m_cnt;
  bit  prev_v, prev_m;
  int  total = 0;
  int  bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_set(input hash_vec_t h);
    for (int i = 0; i < NH; i++) if (!bank_m[i][h[i]]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_wipe();
    for (int i = 0; i < NH; i++) bank_m[i] = '0;
  endtask

  // One clock: checks ready before the edge, updates the model at the edge,
  // then checks registered outputs against the model.
  task automatic cycle();
    bit acc, clr_now, lv, lm;
    #1;
    clr_now = clear_i;
    acc     = !m_busy && !clear_i && prog_val_i;
    chk("prog_ready", prog_ready_o, {31'd0, !m_busy && !clear_i});
    lv = hash_val_i;
    lm = hash_val_i && !m_busy && !clear_i && all_set(hash_i);
    @(posedge clk);
    #1;
    if (acc) begin
      for (int i = 0; i < NH; i++) bank_m[i][prog_hash_i[i]] = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (clr_now) begin
      m_busy = 1'b1;
      m_left = DEPTH;
      m_cnt  = 0;
      model_wipe();
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
    end
    chk("busy", busy_o, {31'd0, m_busy});
    chk("prog_cnt", prog_cnt_o, m_cnt);
    chk("match_val", match_val_o, {31'd0, prev_v});
    chk("match", match_o, {31'd0, prev_m});
    prev_v = lv;
    prev_m = lm;
  endtask

  task automatic idle_inputs();
    clear_i    = 1'b0;
    prog_val_i = 1'b0;
    hash_val_i = 1'b0;
  endtask

  function automatic hash_vec_t rand_vec();
    hash_vec_t v;
    for (int i = 0; i < NH; i++) v[i] = HW'($urandom_range(DEPTH-1, 0));
    return v;
  endfunction

  hash_vec_t set_a, set_b, set_c;
  hash_vec_t pool [4];
  int nbusy;

  initial begin
    // 1: reset held three cycles, then a full sweep
    idle_inputs();
    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    m_busy = 1'b1; m_left = DEPTH; m_cnt = 0; prev_v = 0; prev_m = 0;
    model_wipe();
    chk("rst_busy", busy_o, 1);
    chk("rst_match_val", match_val_o, 0);
    chk("rst_match", match_o, 0);
    chk("rst_prog_cnt", prog_cnt_o, 0);
    chk("rst_ready", prog_ready_o, 0);
    nbusy = 0;
    for (int k = 0; k < 5000; k++) begin
      cycle();
      nbusy++;
      if (!busy_o) break;
    end
    chk("reset_sweep_len", nbusy, DEPTH);

    // 2: lookup right after the sweep misses
    for (int i = 0; i < NH; i++) hash_i[i] = HW'(i*5);
    hash_val_i = 1'b1;
    cycle();
    hash_val_i = 1'b0;
    cycle();
    cycle();

    // 3: program a pattern, look it up one cycle later, then a near miss
    for (int i = 0; i < NH; i++) set_a[i] = HW'(i*'h111);
    prog_hash_i = set_a; prog_val_i = 1'b1;
    cycle();
    prog_val_i = 1'b0;
    hash_i = set_a; hash_val_i = 1'b1;
    cycle();
    hash_i[9] = 12'h99A;
    cycle();
    hash_val_i = 1'b0;
    cycle();
    cycle();
    chk("prog_cnt_one", prog_cnt_o, 1);

    // 4: same-cycle program and lookup sees old data; next cycle sees new
    set_c = rand_vec();
    prog_hash_i = set_c; prog_val_i = 1'b1;
    hash_i = set_c; hash_val_i = 1'b1;
    cycle();
    prog_val_i = 1'b0;
    cycle();
    hash_val_i = 1'b0;
    cycle();
    cycle();

    // 5: 64 back-to-back lookups alternating hit/miss
    set_b = rand_vec();
    for (int k = 0; k < 64; k++) begin
      hash_i = (k % 2 == 0) ? set_a : set_b;
      hash_val_i = 1'b1;
      cycle();
    end
    hash_val_i = 1'b0;
    cycle();
    cycle();

    // Random mix of programs and lookups over a small pool of patterns
    for (int p = 0; p < 4; p++) pool[p] = rand_vec();
    for (int k = 0; k < 400; k++) begin
      prog_hash_i = pool[$urandom_range(3, 0)];
      prog_val_i  = ($urandom_range(3, 0) == 0);
      hash_i      = ($urandom_range(4, 0) == 0) ? rand_vec() : pool[$urandom_range(3, 0)];
      hash_val_i  = $urandom_range(1, 0);
      cycle();
    end
    idle_inputs();
    cycle();
    cycle();

    // 6: clear, then restart it 2000 cycles into the sweep
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    repeat (2000) cycle();
    clear_i = 1'b1;
    hash_i = set_a; hash_val_i = 1'b1;
    cycle();
    idle_inputs();
    nbusy = 0;
    for (int k = 0; k < 5000; k++) begin
      cycle();
      nbusy++;
      if (!busy_o) break;
    end
    chk("restart_sweep_len", nbusy, DEPTH);

    // Reprogram, then clear in IDLE with a simultaneous program request
    prog_hash_i = set_a; prog_val_i = 1'b1;
    cycle();
    prog_val_i = 1'b0;
    chk("prog_cnt_reprog", prog_cnt_o, 1);
    clear_i = 1'b1; prog_val_i = 1'b1; prog_hash_i = set_c;
    cycle();
    idle_inputs();
    chk("prog_cnt_after_clear", prog_cnt_o, 0);
    for (int k = 0; k < 5000 && busy_o; k++) cycle();
    hash_i = set_a; hash_val_i = 1'b1;
    cycle();
    hash_val_i = 1'b0;
    cycle();
    cycle();
    chk("prog_cnt_final", prog_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
